// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if -- bundle of the core request/response handshake and the memory
// bus of the load/store unit.
//
// Modports:
//   slave  : the LSU itself. It receives core requests and memory responses,
//            and drives the core response and the memory request.
//   master : the environment around the LSU (core plus memory). It drives
//            req_* and mem_ack/mem_rdata, and observes everything else.
//
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : core request
//   rsp_valid/rsp_rdata/rsp_err                              : core response
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata              : memory request
//   mem_ack/mem_rdata                                        : memory response
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [AWIDTH-1:0] req_addr;
   logic [DWIDTH-1:0] req_wdata;

   logic              rsp_valid;
   logic [DWIDTH-1:0] rsp_rdata;
   logic              rsp_err;

   logic              mem_req;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [DWIDTH-1:0] mem_wdata;
   logic              mem_ack;
   logic [DWIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- single-outstanding load/store controller.
//
// Accepts one core access at a time, turns it into a word-aligned memory
// request with byte-lane strobes and lane-replicated store data, waits for the
// memory acknowledge (bounded by TIMEOUT cycles) and returns a one-cycle
// response carrying sign/zero-extended load data or an error flag.
//
// Parameters:
//   DWIDTH  : data width (lane logic assumes 32, i.e. four byte lanes)
//   AWIDTH  : address width
//   TIMEOUT : maximum number of ISSUE cycles spent waiting for mem_ack
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous reset, active low
//   bus : lsu_ctrl_if.slave -- core request/response and memory bus
//
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, halfword accesses with addr[0] = 1 and
//   word accesses with addr[1:0] != 00 are rejected with an error response and
//   no memory access. When undefined, those low address bits are ignored and
//   the access proceeds on the aligned half/word.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic      clk,
   input  logic      rst,
   lsu_ctrl_if.slave bus
);

   localparam int NLANE = DWIDTH / 8;
   localparam int CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [2:0]        f3_reg;
   logic [1:0]        alo_reg;
   logic              we_reg;

   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic [DWIDTH-1:0] rsp_rdata_reg;
   logic              mem_req_reg;
   logic              mem_we_reg;
   logic [AWIDTH-1:0] mem_addr_reg;
   logic [3:0]        mem_wstrb_reg;
   logic [DWIDTH-1:0] mem_wdata_reg;

   // ---------------------------------------------------------------------------
   // Request legality
   // ---------------------------------------------------------------------------
   logic f3_bad;
   logic misalign;
   logic req_illegal;

   always_comb begin
      f3_bad = 1'b0;
      case (bus.req_funct3)
         F3_B, F3_H, F3_W: f3_bad = 1'b0;
         F3_BU, F3_HU:     f3_bad = bus.req_we;   // unsigned forms are load-only
         default:          f3_bad = 1'b1;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0])
                   || ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
`else
   // Low address bits are simply dropped by the lane selection below.
   assign misalign = 1'b0;
`endif

   assign req_illegal = f3_bad | misalign;

   // ---------------------------------------------------------------------------
   // Store path: lane replication and strobes
   // ---------------------------------------------------------------------------
   logic [DWIDTH-1:0] rep_b;
   logic [DWIDTH-1:0] rep_h;
   logic [DWIDTH-1:0] st_wdata;
   logic [3:0]        st_wstrb;

   genvar gi;
   generate
      for (gi = 0; gi < NLANE; gi++) begin : g_rep
         assign rep_b[8*gi +: 8] = bus.req_wdata[7:0];
         assign rep_h[8*gi +: 8] = bus.req_wdata[8*(gi % 2) +: 8];
      end
   endgenerate

   // Store funct3 1xx never gets here (illegal), so only the size bits matter.
   always_comb begin
      st_wdata = bus.req_wdata;
      st_wstrb = 4'b1111;
      case (bus.req_funct3[1:0])
         2'b00: begin
            st_wdata = rep_b;
            st_wstrb = 4'b0001 << bus.req_addr[1:0];
         end
         2'b01: begin
            st_wdata = rep_h;
            st_wstrb = 4'b0011 << {bus.req_addr[1], 1'b0};
         end
         default: begin
            st_wdata = bus.req_wdata;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Load path: lane select and extension from the live mem_rdata, so the
   // formatted value can be registered on the acknowledge edge.
   // ---------------------------------------------------------------------------
   logic [7:0]        rd_byte [NLANE];
   logic [15:0]       rd_half [NLANE/2];
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DWIDTH-1:0] ld_data;

   generate
      for (gi = 0; gi < NLANE; gi++) begin : g_rdb
         assign rd_byte[gi] = bus.mem_rdata[8*gi +: 8];
      end
      for (gi = 0; gi < NLANE/2; gi++) begin : g_rdh
         assign rd_half[gi] = bus.mem_rdata[16*gi +: 16];
      end
   endgenerate

   assign ld_byte = rd_byte[alo_reg];
   assign ld_half = rd_half[alo_reg[1]];

   always_comb begin
      ld_data = bus.mem_rdata;
      case (f3_reg)
         F3_B:    ld_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
         F3_BU:   ld_data = {{(DWIDTH-8){1'b0}}, ld_byte};
         F3_HU:   ld_data = {{(DWIDTH-16){1'b0}}, ld_half};
         default: ld_data = bus.mem_rdata;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         f3_reg        <= '0;
         alo_reg       <= '0;
         we_reg        <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wstrb_reg <= 4'b0000;
         mem_wdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.req_valid) begin
                  f3_reg  <= bus.req_funct3;
                  alo_reg <= bus.req_addr[1:0];
                  we_reg  <= bus.req_we;
                  if (req_illegal) begin
                     // Fault without touching memory.
                     state_reg     <= RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= 1'b1;
                     rsp_rdata_reg <= '0;
                  end else begin
                     state_reg     <= ISSUE;
                     cnt_reg       <= '0;
                     mem_req_reg   <= 1'b1;
                     mem_we_reg    <= bus.req_we;
                     mem_addr_reg  <= {bus.req_addr[AWIDTH-1:2], 2'b00};
                     mem_wstrb_reg <= bus.req_we ? st_wstrb : 4'b0000;
                     mem_wdata_reg <= bus.req_we ? st_wdata : '0;
                  end
               end
            end

            ISSUE: begin
               // Acknowledge takes priority over a coincident timeout.
               if (bus.mem_ack) begin
                  state_reg     <= RESP;
                  mem_req_reg   <= 1'b0;
                  mem_we_reg    <= 1'b0;
                  mem_wstrb_reg <= 4'b0000;
                  rsp_valid_reg <= 1'b1;
                  rsp_err_reg   <= 1'b0;
                  rsp_rdata_reg <= we_reg ? '0 : ld_data;
               end else if (cnt_reg == LAST_WAIT) begin
                  // Counter reaches TIMEOUT on this edge: abandon the access.
                  cnt_reg       <= cnt_reg + 1'b1;
                  state_reg     <= RESP;
                  mem_req_reg   <= 1'b0;
                  mem_we_reg    <= 1'b0;
                  mem_wstrb_reg <= 4'b0000;
                  rsp_valid_reg <= 1'b1;
                  rsp_err_reg   <= 1'b1;
                  rsp_rdata_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            RESP: begin
               state_reg     <= IDLE;
               rsp_valid_reg <= 1'b0;
               rsp_err_reg   <= 1'b0;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = (state_reg == IDLE);
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wstrb = mem_wstrb_reg;
   assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- directed self-checking bench for lsu_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   lsu_ctrl_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

   lsu_ctrl #(
      .DWIDTH (32),
      .AWIDTH (32),
      .TIMEOUT(15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
   endtask

   // Present a request for one cycle; returns in the first ISSUE/RESP cycle.
   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      drive_req(we, f3, addr, wdata);
      tick();
      bus.req_valid = 1'b0;
   endtask

   // Acknowledge for one cycle; returns in the RESP cycle.
   task automatic ack(input logic [31:0] rdata);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      tick();
      bus.mem_ack   = 1'b0;
   endtask

   task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rdata, input logic [31:0] exp_addr,
                       input logic [31:0] exp_data);
      issue(1'b0, f3, addr, 32'h0);
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
      chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, ".wstrb"}, 32'(bus.mem_wstrb), 32'h0);
      ack(rdata);
      chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
      chk({tag, ".rdata"}, bus.rsp_rdata, exp_data);
      $display("load  %s addr=%h mem_rdata=%h -> rsp_rdata=%h", tag, addr, rdata, bus.rsp_rdata);
      tick();
      chk({tag, ".idle"}, 32'(bus.req_ready), 32'd1);
   endtask

   task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      issue(1'b1, f3, addr, wdata);
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'd1);
      chk({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
      chk({tag, ".wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb));
      chk({tag, ".wdata"}, bus.mem_wdata, exp_wdata);
      chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd0);
      ack(32'hFFFF_FFFF);
      chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
      chk({tag, ".rdata"}, bus.rsp_rdata, 32'h0);
      $display("store %s addr=%h wdata=%h -> mem_addr=%h wstrb=%b", tag, addr, wdata,
               exp_addr, exp_strb);
      tick();
      chk({tag, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   task automatic illegal(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
      issue(we, f3, addr, 32'h1234_5678);
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd0);
      chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd1);
      chk({tag, ".rdata"}, bus.rsp_rdata, 32'h0);
      $display("illegal %s we=%0b funct3=%b -> err", tag, we, f3);
      tick();
      chk({tag, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = 32'h0;

      // Reset state
      tick();
      tick();
      chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst.mem_addr", bus.mem_addr, 32'h0);
      chk("rst.mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst.wstrb", 32'(bus.mem_wstrb), 32'h0);
      chk("rst.rdata", bus.rsp_rdata, 32'h0);
      $display("reset released");
      rst = 1'b1;
      tick();

      // Stores: lane replication and strobes
      store("SB13", 3'b000, 32'h13, 32'h0000_00A5, 32'h10, 4'b1000, 32'hA5A5_A5A5);
      store("SB40", 3'b000, 32'h40, 32'h0000_0077, 32'h40, 4'b0001, 32'h7777_7777);
      store("SH16", 3'b001, 32'h16, 32'h1234_ABCD, 32'h14, 4'b1100, 32'hABCD_ABCD);
      store("SW30", 3'b010, 32'h30, 32'hCAFE_F00D, 32'h30, 4'b1111, 32'hCAFE_F00D);

      // Loads: lane select and extension
      load("LB12",  3'b000, 32'h12, 32'h00F0_0000, 32'h10, 32'hFFFF_FFF0);
      load("LBU12", 3'b100, 32'h12, 32'h00F0_0000, 32'h10, 32'h0000_00F0);
      load("LH22",  3'b001, 32'h22, 32'h8001_7FFF, 32'h20, 32'hFFFF_8001);
      load("LHU20", 3'b101, 32'h20, 32'h8001_F00F, 32'h20, 32'h0000_F00F);
      load("LW24",  3'b010, 32'h24, 32'hDEAD_BEEF, 32'h24, 32'hDEAD_BEEF);

      // Misaligned halfword
`ifdef LSU_MISALIGN_TRAP_EN
      illegal("LH21", 1'b0, 3'b001, 32'h21);
`else
      load("LH21", 3'b001, 32'h21, 32'h1234_5678, 32'h20, 32'h0000_5678);
`endif

      // Illegal encodings
      illegal("F3_011", 1'b0, 3'b011, 32'h80);
      illegal("SBU", 1'b1, 3'b100, 32'h84);

      // Back-to-back: new request offered in the first IDLE cycle, 3 cycles apart
      issue(1'b0, 3'b010, 32'h90, 32'h0);
      ack(32'h1111_1111);
      tick();
      issue(1'b0, 3'b010, 32'h94, 32'h0);
      chk("b2b.mem_req", 32'(bus.mem_req), 32'd1);
      chk("b2b.mem_addr", bus.mem_addr, 32'h94);
      ack(32'h2222_2222);
      chk("b2b.rdata", bus.rsp_rdata, 32'h2222_2222);
      $display("back-to-back LW 0x90/0x94 accepted 3 cycles apart");
      tick();

      // Timeout: no ack for 15 ISSUE cycles; a second request during ISSUE is ignored
      issue(1'b0, 3'b010, 32'h50, 32'h0);
      drive_req(1'b1, 3'b000, 32'hA0, 32'h55);
      bus.mem_rdata = 32'h5A5A_5A5A;
      repeat (14) tick();
      chk("tmo.mem_req_held", 32'(bus.mem_req), 32'd1);
      chk("tmo.addr_stable", bus.mem_addr, 32'h50);
      chk("tmo.we_stable", 32'(bus.mem_we), 32'd0);
      chk("tmo.no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("tmo.mem_req_drop", 32'(bus.mem_req), 32'd0);
      chk("tmo.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tmo.rsp_err", 32'(bus.rsp_err), 32'd1);
      chk("tmo.rdata", bus.rsp_rdata, 32'h0);
      $display("timeout LW 0x50 -> err after 15 wait cycles");
      bus.req_valid = 1'b0;
      tick();
      chk("tmo.ready", 32'(bus.req_ready), 32'd1);
      tick();
      chk("tmo.no_accept", 32'(bus.mem_req), 32'd0);

      // Ack on the last allowed cycle wins over the timeout
      issue(1'b0, 3'b010, 32'h60, 32'h0);
      repeat (14) tick();
      ack(32'h0BAD_F00D);
      chk("ackwin.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("ackwin.rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("ackwin.rdata", bus.rsp_rdata, 32'h0BAD_F00D);
      $display("LW 0x60 ack on 15th cycle -> data %h", bus.rsp_rdata);
      tick();

      // Stray ack in IDLE is ignored
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("stray.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("stray.ready", 32'(bus.req_ready), 32'd1);
      $display("stray mem_ack in IDLE ignored");

      // Reset during ISSUE
      issue(1'b0, 3'b010, 32'h70, 32'h0);
      rst = 1'b0;
      tick();
      chk("rstiss.mem_req", 32'(bus.mem_req), 32'd0);
      chk("rstiss.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rstiss.mem_addr", bus.mem_addr, 32'h0);
      rst = 1'b1;
      tick();
      chk("rstiss.ready", 32'(bus.req_ready), 32'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("rstiss.no_rsp", 32'(bus.rsp_valid), 32'd0);
      $display("reset during ISSUE discards LW 0x70");

      // Reset during RESP
      issue(1'b1, 3'b010, 32'h74, 32'h1);
      ack(32'h0);
      chk("rstrsp.pre", 32'(bus.rsp_valid), 32'd1);
      rst = 1'b0;
      tick();
      chk("rstrsp.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rstrsp.wdata", bus.mem_wdata, 32'h0);
      rst = 1'b1;
      tick();
      chk("rstrsp.ready", 32'(bus.req_ready), 32'd1);
      $display("reset during RESP clears response");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
